// File: rtl/gcn_host_seq.sv
// Host-side sequencer: streams ROM words into the GCN accelerator, then drains its result stream into RAM.
// Optional golden-result checking is enabled by defining GCN_HOST_CHECK_EN.
module gcn_host_seq #(
    parameter int N_IN       = 2512,
    parameter int IN_AW      = 12,
    parameter int N_ROWS     = 100,
    parameter int REQ_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IN_AW-1:0] rom_addr,
    input  logic [16:0]      rom_data,
    output logic             acc_req,
    output logic             acc_cmd,
    output logic [15:0]      acc_p,
    input  logic             acc_rdy,
    input  logic             acc_result,
    input  logic [15:0]      acc_q,
    output logic             res_we,
    output logic [9:0]       res_addr,
    output logic [15:0]      res_data,
    output logic [2:0]       col1,
    output logic [2:0]       col2,
    output logic             hdr_err,
    output logic             load_ovf,
`ifdef GCN_HOST_CHECK_EN
    output logic [9:0]       gold_addr,
    input  logic [15:0]      gold_data,
    output logic [7:0]       err_cnt,
    output logic             pass,
`endif
    output logic             drain_ovf
);
    localparam int CW = $clog2(2 * N_ROWS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_HDR   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IN_AW-1:0] LAST_IDX = IN_AW'(N_IN - 1);
    localparam logic [CW-1:0]    TOTAL    = CW'(2 * N_ROWS);

    logic [2:0]       state;
    logic [IN_AW-1:0] idx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    row;
    logic [2:0]       col_sel;
    logic             in_load, in_drain, valid;

    assign in_load  = (state == S_LOAD);
    assign in_drain = (state == S_DRAIN);
    assign valid    = acc_rdy && !acc_result;

    assign busy     = in_load || (state == S_HDR) || in_drain;
    assign done     = (state == S_DONE);
    assign rom_addr = in_load ? idx : '0;
    assign acc_req  = in_load && (idx < IN_AW'(REQ_CYCLES));
    assign acc_cmd  = in_load ? rom_data[16] : 1'b0;
    assign acc_p    = in_load ? rom_data[15:0] : 16'h0;

    // First N_ROWS results fill column col1, the next N_ROWS fill col2.
    assign row      = (cnt < CW'(N_ROWS)) ? cnt : cnt - CW'(N_ROWS);
    assign col_sel  = (cnt < CW'(N_ROWS)) ? col1 : col2;
    assign res_we   = in_drain && valid && (cnt != TOTAL);
    assign res_addr = in_drain ? 10'({row, col_sel}) : 10'h0;
    assign res_data = in_drain ? acc_q : 16'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            cnt       <= '0;
            col1      <= '0;
            col2      <= '0;
            hdr_err   <= 1'b0;
            load_ovf  <= 1'b0;
            drain_ovf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state     <= S_LOAD;
                    idx       <= '0;
                    cnt       <= '0;
                    hdr_err   <= 1'b0;
                    load_ovf  <= 1'b0;
                    drain_ovf <= 1'b0;
                end
                // acc_rdy takes priority over an advance in the same cycle.
                S_LOAD: if (acc_rdy) begin
                    state <= S_HDR;
                end else if (!acc_result) begin
                    if (idx == LAST_IDX) load_ovf <= 1'b1;
                    else                 idx      <= idx + 1'b1;
                end
                S_HDR: if (!acc_rdy) begin
                    state <= S_DONE;
                end else if (!acc_result) begin
                    col1  <= acc_q[2:0];
                    col2  <= acc_q[10:8];
                    if ((acc_q[7:0] > 8'd7) || (acc_q[15:8] > 8'd7)) hdr_err <= 1'b1;
                    state <= S_DRAIN;
                end
                S_DRAIN: if (!acc_rdy) begin
                    state <= S_DONE;
                end else if (!acc_result) begin
                    if (cnt == TOTAL) drain_ovf <= 1'b1;
                    else              cnt       <= cnt + 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef GCN_HOST_CHECK_EN
    assign gold_addr = res_addr;
    assign pass      = done && (err_cnt == 8'h0) && !hdr_err && !load_ovf && !drain_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= 8'h0;
        else if ((state == S_IDLE) && start)
            err_cnt <= 8'h0;
        else if (res_we && (gold_data != res_data) && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 1'b1;
    end
`endif
endmodule

// File: doc/gcn_host_seq.md
Name: gcn_host_seq

Overview:
- Synthesizable host-side sequencer for the GCN accelerator command/data port; it replaces the behavioural bench driver so the accelerator can run on-chip.
- Streams {cmd, data} words from an input ROM into the accelerator until the accelerator raises its ready flag.
- Then collects the result stream: one column-header word followed by 2*N_ROWS data words.
- Writes each result word to a result RAM at row*8+col.

Parameters:
- N_IN, 2512, number of input words in the ROM.
- IN_AW, 12, ROM address width.
- N_ROWS, 100, result rows per column; two columns per run.
- REQ_CYCLES, 2, number of leading load words driven with acc_req high.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse that begins a run; ignored unless IDLE.
- busy  out  1  high from LOAD through DRAIN.
- done  out  1  one-cycle pulse when a run ends.
- rom_addr  out  IN_AW  input ROM address; the ROM read is combinational.
- rom_data  in  17  {cmd, data[15:0]} at rom_addr.
- acc_req  out  1  request to the accelerator.
- acc_cmd  out  1  command bit.
- acc_p  out  16  data word.
- acc_rdy  in  1  accelerator output phase active.
- acc_result  in  1  during LOAD, high means stall; during DRAIN, high means the word is invalid.
- acc_q  in  16  accelerator output word.
- res_we  out  1  result write enable.
- res_addr  out  10  row*8+col.
- res_data  out  16  result word.
- col1, col2  out  3  column indices from the header, registered.
- hdr_err, load_ovf, drain_ovf  out  1  sticky error flags, cleared on start.

Behaviour:
- Reset: all outputs are 0, state is IDLE, all counters are 0. Reset mid-run aborts immediately, with no done pulse.
- IDLE:
  - start clears idx, cnt and the sticky flags, then goes to LOAD.
- LOAD:
  - Each cycle: rom_addr=idx; acc_p and acc_cmd come from rom_data, combinationally.
  - acc_req=1 while idx<REQ_CYCLES, else 0.
  - acc_result=0 at the posedge: idx increments.
  - acc_result=1 at the posedge: idx holds and the same word is redriven.
  - If idx=N_IN-1 and an advance is requested: idx saturates and load_ovf is set.
  - acc_rdy=1 sampled: go to HDR. This wins over an advance in the same cycle. acc_req, acc_cmd and acc_p go to 0 from the next cycle.
- HDR:
  - First cycle with acc_rdy=1 and acc_result=0: acc_q[7:0] is col1 and acc_q[15:8] is col2. Register their low 3 bits.
  - If either byte is >7, set hdr_err.
  - Go to DRAIN.
  - acc_rdy=0 while in HDR: go to DONE with no writes.
- DRAIN:
  - A valid word is acc_rdy=1 and acc_result=0. On a valid word with cnt<2*N_ROWS:
    - res_we=1 in the same cycle.
    - res_data=acc_q.
    - res_addr = cnt*8+col1 for cnt<N_ROWS, else (cnt-N_ROWS)*8+col2.
    - cnt increments.
  - Valid word with cnt=2*N_ROWS: no write; drain_ovf is set.
  - acc_rdy=1 with acc_result=1: no write, cnt holds.
  - acc_rdy=0: go to DONE.
  - res_we, res_addr and res_data are combinational from registered state plus the acc inputs; res_we is never high outside DRAIN.
- DONE:
  - done=1 for one cycle, then IDLE.
  - busy is 0 in DONE and IDLE.
- Latency:
  - start to first acc_p word: 1 cycle.
  - acc_rdy rise to HDR: 1 cycle.
- Simultaneous start and rst: rst wins.

Optional Feature:
- Macro GCN_HOST_CHECK_EN.
- When defined, the block adds:
  - ports gold_addr out 10, equal to res_addr;
  - gold_data in 16, a combinational golden ROM;
  - err_cnt out 8, saturating, cleared on start;
  - pass out 1.
- On every res_we, gold_data is compared with res_data and err_cnt increments on mismatch.
- pass=1 in DONE iff err_cnt=0 and all three error flags are 0.
- When undefined, these ports and the logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic run:
  - Stimulus: ROM words 0..9 = 0x0000..0x0009, cmd=idx[0]. acc_result=0. acc_rdy rises after 10 words. Header 0x0302, then 200 words 0x1000+k.
  - Response: acc_req=1 only on words 0 and 1. col1=2, col2=3. Writes land at addresses 2, 10, ..., 794 and 3, 11, ..., 795 with data 0x1000..0x10C7. One done pulse.
- Stall:
  - Stimulus: acc_result=1 for 3 cycles while idx=4.
  - Response: word 4 is held on acc_p for 4 cycles; idx resumes at 5; no word is skipped.
- Drain gaps and overflow:
  - Stimulus: acc_result=1 on every 3rd drain cycle; then 201 valid words.
  - Response: gap cycles produce no res_we; exactly 200 writes; drain_ovf=1.
- Header error:
  - Stimulus: header 0x0A01.
  - Response: hdr_err=1; col2=2 (0x0A truncated to 3 bits).
- Reset mid-drain:
  - Stimulus: rst asserted after 50 writes, then start.
  - Response: all outputs 0 with no done pulse; the new run starts at idx=0, cnt=0 with the flags clear.
- With GCN_HOST_CHECK_EN:
  - Stimulus: golden ROM differs at address 10 only.
  - Response: err_cnt=1 and pass=0 in DONE; with matching gold, pass=1.
